// File: rtl/uart_io_pkg.sv
// Shared constants for the buffered UART IO bridge: register addresses,
// STATUS bit layout and the TX drain FSM state encoding.
package uart_io_pkg;

  localparam logic [11:0] UART_STATUS_ADDR = 12'h000;
  localparam logic [11:0] UART_DATA_ADDR   = 12'h008;

  localparam int unsigned ST_TX_FULL_BIT     = 0;
  localparam int unsigned ST_RX_NONEMPTY_BIT = 1;
  localparam int unsigned ST_RX_OVERRUN_BIT  = 2;
  localparam int unsigned ST_TX_OVERFLOW_BIT = 3;
  localparam int unsigned ST_RX_COUNT_LSB    = 8;
  localparam int unsigned ST_RX_COUNT_W      = 9;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_SETTLE = 2'd1,
    TX_WAIT   = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_io_bridge_sync_fifo.sv
// Synchronous FIFO, power-of-two depth. Head is presented combinationally
// on rdata; a push on a full FIFO is accepted when a pop happens the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage array write; contents need no reset since count gates reads.
  always_ff @(posedge clk_sys) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_io_bridge.sv
// Buffered UART peripheral on the CPU IO bus: STATUS at 0x000, DATA at 0x008,
// TX and RX FIFOs between the bus and the byte-level UART core.
// Build option: define UART_LOOPBACK_EN to route TX FIFO bytes straight into
// the RX FIFO (no TX strobes; external RX bytes acknowledged and discarded).
module uart_io_bridge
  import uart_io_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        io_read_valid_i,
  input  logic        io_write_valid_i,
  input  logic [11:0] io_addr_i,
  input  logic [31:0] io_wdata_i,
  output logic [31:0] io_rdata_o,
  output logic [7:0]  uart_tx_data_o,
  output logic        uart_tx_strobe_o,
  input  logic        uart_tx_busy_i,
  input  logic [7:0]  uart_rx_data_i,
  input  logic        uart_rx_valid_i,
  output logic        uart_rx_strobe_o
);

  logic                     rd_data, wr_data, wr_status;
  logic                     tx_push, tx_pop, tx_full, tx_empty, tx_drop;
  logic [7:0]               tx_head;
  logic [$clog2(TX_DEPTH):0] unused_tx_count;
  logic                     rx_push, rx_pop, rx_full, rx_empty, rx_drop, rx_take;
  logic [7:0]               rx_head, rx_wdata;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic                     rx_overrun_q, tx_overflow_q;
  logic                     send;
  logic [7:0]               tx_last_q;
  logic [31:0]              rdata_d;
  tx_state_t                state_q, state_d;
`ifdef UART_LOOPBACK_EN
  logic                     lb_move;
`endif

  assign rd_data   = io_read_valid_i  && (io_addr_i == UART_DATA_ADDR);
  assign wr_data   = io_write_valid_i && (io_addr_i == UART_DATA_ADDR);
  assign wr_status = io_write_valid_i && (io_addr_i == UART_STATUS_ADDR);

  assign tx_push = wr_data;
  assign tx_drop = wr_data && tx_full && !tx_pop;
  assign rx_take = uart_rx_valid_i && !uart_rx_strobe_o;
  assign rx_pop  = rd_data && !rx_empty;

`ifdef UART_LOOPBACK_EN
  assign rx_push          = lb_move;
  assign rx_wdata         = tx_head;
  assign rx_drop          = 1'b0;
  assign uart_tx_strobe_o = 1'b0;
`else
  assign rx_push          = rx_take;
  assign rx_wdata         = uart_rx_data_i;
  assign rx_drop          = rx_take && rx_full && !rx_pop;
  assign uart_tx_strobe_o = send;
`endif

  // Head byte is shown in the send cycle, then held until the next send.
  assign uart_tx_data_o = send ? tx_head : tx_last_q;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (tx_push),
    .pop     (tx_pop),
    .wdata   (io_wdata_i[7:0]),
    .rdata   (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (unused_tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (rx_push),
    .pop     (rx_pop),
    .wdata   (rx_wdata),
    .rdata   (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  // TX drain: next state and send/pop decisions.
  always_comb begin
    state_d = state_q;
    tx_pop  = 1'b0;
    send    = 1'b0;
`ifdef UART_LOOPBACK_EN
    lb_move = 1'b0;
`endif
    case (state_q)
      TX_IDLE: begin
`ifdef UART_LOOPBACK_EN
        if (!tx_empty && !rx_full) begin
          tx_pop  = 1'b1;
          lb_move = 1'b1;
        end
`else
        if (!tx_empty && !uart_tx_busy_i) begin
          tx_pop  = 1'b1;
          send    = 1'b1;
          state_d = TX_SETTLE;
        end
`endif
      end
      TX_SETTLE: state_d = TX_WAIT;
      TX_WAIT:   if (!uart_tx_busy_i) state_d = TX_IDLE;
      default:   state_d = TX_IDLE;
    endcase
  end

  // TX FSM state, last-sent byte and RX acknowledge strobe.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q          <= TX_IDLE;
      tx_last_q        <= '0;
      uart_rx_strobe_o <= 1'b0;
    end else begin
      state_q          <= state_d;
      uart_rx_strobe_o <= rx_take;
      if (send) tx_last_q <= tx_head;
    end
  end

  // Sticky error flags; a same-cycle set wins over a software clear.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      rx_overrun_q  <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      if (wr_status && io_wdata_i[ST_RX_OVERRUN_BIT])  rx_overrun_q  <= 1'b0;
      if (wr_status && io_wdata_i[ST_TX_OVERFLOW_BIT]) tx_overflow_q <= 1'b0;
      if (rx_drop) rx_overrun_q  <= 1'b1;
      if (tx_drop) tx_overflow_q <= 1'b1;
    end
  end

  // Read mux from address alone; DATA shows the RX head (the byte a pop takes).
  always_comb begin
    rdata_d = '0;
    case (io_addr_i)
      UART_STATUS_ADDR: begin
        rdata_d[ST_TX_FULL_BIT]     = tx_full;
        rdata_d[ST_RX_NONEMPTY_BIT] = !rx_empty;
        rdata_d[ST_RX_OVERRUN_BIT]  = rx_overrun_q;
        rdata_d[ST_TX_OVERFLOW_BIT] = tx_overflow_q;
        rdata_d[ST_RX_COUNT_LSB +: ST_RX_COUNT_W] = ST_RX_COUNT_W'(rx_count);
      end
      UART_DATA_ADDR: begin
        if (!rx_empty) rdata_d[7:0] = rx_head;
      end
      default: rdata_d = '0;
    endcase
  end

  // Registered read data, one cycle after the address.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      io_rdata_o <= '0;
    end else begin
      io_rdata_o <= rdata_d;
    end
  end

endmodule

// File: doc/uart_io_bridge.md
# uart_io_bridge

Buffered UART peripheral on the CPU IO bus. It sits between the memory controller's IO port (read/write strobes, address, write data, registered read data) and the byte-level UART core. It decouples CPU stores and loads from serial timing through a TX FIFO and an RX FIFO. It replaces the unbuffered UART register decode in the system-control logic, exposing STATUS at 0x000 and DATA at 0x008.

## Interface
- TX_DEPTH, 16: TX FIFO entries; power of two, 2..256.
- RX_DEPTH, 16: RX FIFO entries; power of two, 2..256.
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- io_read_valid_i  in  1  one-cycle IO read strobe.
- io_write_valid_i  in  1  one-cycle IO write strobe.
- io_addr_i  in  12  IO byte address; decode uses [11:0] only.
- io_wdata_i  in  32  IO write data.
- io_rdata_o  out  32  registered read data.
- uart_tx_data_o  out  8  byte to UART core.
- uart_tx_strobe_o  out  1  one-cycle send request.
- uart_tx_busy_i  in  1  UART core transmitting.
- uart_rx_data_i  in  8  received byte.
- uart_rx_valid_i  in  1  received byte available.
- uart_rx_strobe_o  out  1  one-cycle acknowledge of uart_rx_data_i.

## Operation
- STATUS (0x000) read layout:
  - bit0 tx_full.
  - bit1 rx_nonempty.
  - bit2 rx_overrun (sticky).
  - bit3 tx_overflow (sticky).
  - bits[16:8] rx_count, 9 bits.
  - all other bits 0.
- STATUS write: writing 1 to bit2 or bit3 clears that sticky flag. Other bits are ignored.
- DATA (0x008) write pushes io_wdata_i[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and tx_overflow is set.
- DATA read pops the RX FIFO. When the FIFO is empty, nothing is popped and the data field reads 0.
- Any other address reads 0x0000_0000. Writes to other addresses are ignored.
- RX intake: whenever uart_rx_valid_i=1 and uart_rx_strobe_o was not asserted the previous cycle:
  - assert uart_rx_strobe_o for one cycle;
  - push the byte into the RX FIFO;
  - if the FIFO is full (after any same-cycle pop), drop the byte and set rx_overrun.
- Simultaneous push and pop on a full FIFO: the pop frees a slot and the push is accepted. This applies to both FIFOs.
- TX drain FSM:
  - TX_IDLE: if the TX FIFO is non-empty and uart_tx_busy_i=0, present the head byte on uart_tx_data_o, assert uart_tx_strobe_o, pop the FIFO, and go to TX_SETTLE.
  - TX_SETTLE: wait one cycle for the core to raise busy, then go to TX_WAIT.
  - TX_WAIT: when uart_tx_busy_i=0, go to TX_IDLE.
- uart_tx_data_o holds the last sent byte until the next send.

## Timing
- io_rdata_o is registered every cycle from io_addr_i. Latency is 1 cycle and does not depend on strobes.
- On a DATA read strobe, io_rdata_o in the next cycle holds the byte popped by that read, i.e. the head before the pop.
- STATUS reflects FIFO state as of the previous clock edge.
- A CPU write to DATA reaches the TX FIFO at the strobe edge. The earliest uart_tx_strobe_o is the following cycle.
- Back-to-back sends are at least 3 cycles apart.
- A received byte is readable via DATA 2 cycles after uart_rx_valid_i rises: one edge to push, one to register rdata.
- Reset values:
  - io_rdata_o=0;
  - uart_tx_strobe_o=0, uart_rx_strobe_o=0, uart_tx_data_o=0;
  - FIFOs empty, sticky flags 0, FSM in TX_IDLE.
- Reset asserted mid-transmission: FIFO contents are discarded and the FSM returns to TX_IDLE. The UART core finishes its byte on its own.

## Configuration
- UART_LOOPBACK_EN defined:
  - uart_tx_strobe_o is held 0.
  - The TX FSM moves one byte per cycle from the TX FIFO head into the RX FIFO, and only when the RX FIFO is not full (no overrun is flagged).
  - External RX bytes are still strobed and discarded without setting rx_overrun.
- UART_LOOPBACK_EN not defined: normal operation as above.

## Structure
- Package uart_io_pkg holds:
  - address constants UART_STATUS_ADDR=12'h000 and UART_DATA_ADDR=12'h008;
  - STATUS bit-position localparams;
  - the TX FSM state enum.
- One sub-module, sync_fifo, parameterised by WIDTH and DEPTH, with push, pop, full, empty and count outputs. It is instantiated twice.

## Test plan
- Reset, then read STATUS -> io_rdata_o=0x0000_0000. No strobes asserted.
- Write DATA 0x41, 0x42 with busy low, and model busy for 10 cycles after each strobe -> strobes carry 0x41 then 0x42, separated by at least the busy period.
- Write 17 bytes to DATA while busy is held high -> STATUS bit0=1 and bit3=1. Write STATUS 0x8 -> bit3 clears, bit0 stays 1.
- Inject 0x55 via uart_rx_valid_i -> uart_rx_strobe_o pulses once. STATUS reads 0x0000_0102. A DATA read returns 0x0000_0055, then STATUS reads 0.
- Inject 17 RX bytes with no reads -> STATUS bit2=1, rx_count=16. Reading DATA 16 times returns the first 16 bytes in order.
- With UART_LOOPBACK_EN, write 0xA5 to DATA -> no uart_tx_strobe_o. A DATA read returns 0xA5 within 4 cycles of the write.
